// File: rtl/bpred_history_ctrl_if.sv
// Fetch/resolve/predictor-state bundle for the branch history controller.
// Handshake: a fetch update is transferred on a rising clock edge when
// i_fetchValid and o_fetchReady are both high (and i_fetchErr is low);
// a resolve is taken on any edge where i_resolveValid is high while the
// controller is idle, and the producer must keep it low while o_busy is high.
interface bpred_history_ctrl_if;
    logic         i_fetchValid;
    logic         i_fetchErr;
    logic [2:0]   i_passBNum_3;
    logic [35:0]  i_newGHREntry_36;
    logic         o_fetchReady;
    logic         i_resolveValid;
    logic         i_resolveTaken;
    logic         i_resolvePredTaken;
    logic [1:0]   i_resolveSlot_2;
    logic [179:0] o_ghr_180;
    logic [7:0]   o_pendingB_8;
    logic [287:0] o_weights_288;
    logic         o_busy;
    logic         o_trainDone;
    logic         o_underflow;
    logic [1:0]   o_dbgState;

    modport master (
        output i_fetchValid, i_fetchErr, i_passBNum_3, i_newGHREntry_36,
        output i_resolveValid, i_resolveTaken, i_resolvePredTaken, i_resolveSlot_2,
        input  o_fetchReady, o_ghr_180, o_pendingB_8, o_weights_288,
        input  o_busy, o_trainDone, o_underflow, o_dbgState
    );

    modport slave (
        input  i_fetchValid, i_fetchErr, i_passBNum_3, i_newGHREntry_36,
        input  i_resolveValid, i_resolveTaken, i_resolvePredTaken, i_resolveSlot_2,
        output o_fetchReady, o_ghr_180, o_pendingB_8, o_weights_288,
        output o_busy, o_trainDone, o_underflow, o_dbgState
    );
endinterface

// File: rtl/bpred_history_ctrl.sv
// Branch history controller: owns the GHR, the pending-branch count and the
// perceptron weights; commits fetch updates, retires resolves, and on a
// mispredict rolls the GHR back and trains one weight per cycle.
module bpred_history_ctrl (
    input  logic                 i_clk,
    input  logic                 i_rst,
    bpred_history_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ROLLBACK = 2'd1,
        S_TRAIN    = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t       state, stateNext;
    logic [179:0] ghr, ghrNext;
    logic [7:0]   pending, pendingNext;
    logic [287:0] weights, weightsNext;
    logic [3:0]   idx, idxNext;
    logic         latTaken, latTakenNext;
    logic [1:0]   latSlot, latSlotNext;
    logic [7:0]   latD, latDNext;
    logic         trainDone, trainDoneNext;
    logic         underflow, underflowNext;

    logic [2:0]   passB;
    logic [179:0] ghrFetch;
    logic         fetchReady, resolveOk, misp, correct, fetchAcc;
    logic [7:0]   rbShift;
    logic [179:0] ghrRb;
    logic [8:0]   wBase;
    logic [7:0]   ghrBitPos;
    logic         voteUp;
    logic signed [7:0] curW, newW;

    // Commit count is clamped to the four entries a fetch group can carry.
    assign passB      = (bus.i_passBNum_3 > 3'd4) ? 3'd4 : bus.i_passBNum_3;
    // Leave room for a full group of 4 so pending never exceeds 20.
    assign fetchReady = (state == S_IDLE) && (pending <= 8'd16);
    assign resolveOk  = (state == S_IDLE) && bus.i_resolveValid;
    assign misp       = resolveOk && (pending != 8'd0) &&
                        (bus.i_resolveTaken != bus.i_resolvePredTaken);
    assign correct    = resolveOk && (pending != 8'd0) &&
                        (bus.i_resolveTaken == bus.i_resolvePredTaken);
    assign fetchAcc   = bus.i_fetchValid && fetchReady && !bus.i_fetchErr && !misp;

    // Rollback discards the D younger entries so the resolved branch is entry 0.
    assign rbShift    = latD * 8'd9;
    assign ghrRb      = {ghr >> rbShift} | {179'd0, 1'b0};

    // Weight under training and the history bit that votes on it.
    assign wBase      = 9'(latSlot) * 9'd72 + 9'(idx) * 9'd8;
    assign ghrBitPos  = 8'(idx + 4'd1) * 8'd9;
    assign curW       = weights[wBase +: 8];
    assign voteUp     = (idx == 4'd8) ? latTaken : (ghr[ghrBitPos] == latTaken);
    assign newW       = voteUp ? ((curW == 8'sh7F) ? curW : curW + 8'sd1)
                               : ((curW == 8'sh80) ? curW : curW - 8'sd1);

    // GHR after shifting in the committed fetch entries (entry 0 youngest).
    always_comb begin
        ghrFetch = ghr;
        case (passB)
            3'd1:    ghrFetch = {ghr[170:0], bus.i_newGHREntry_36[8:0]};
            3'd2:    ghrFetch = {ghr[161:0], bus.i_newGHREntry_36[17:0]};
            3'd3:    ghrFetch = {ghr[152:0], bus.i_newGHREntry_36[26:0]};
            3'd4:    ghrFetch = {ghr[143:0], bus.i_newGHREntry_36[35:0]};
            default: ghrFetch = ghr;
        endcase
    end

    // Next-state and next-register values for the controller FSM.
    always_comb begin
        stateNext     = state;
        ghrNext       = ghr;
        pendingNext   = pending;
        weightsNext   = weights;
        idxNext       = idx;
        latTakenNext  = latTaken;
        latSlotNext   = latSlot;
        latDNext      = latD;
        trainDoneNext = 1'b0;
        underflowNext = 1'b0;
        case (state)
            S_IDLE: begin
                if (resolveOk && (pending == 8'd0)) begin
                    underflowNext = 1'b1;
                end
                if (misp) begin
                    latTakenNext = bus.i_resolveTaken;
                    latSlotNext  = bus.i_resolveSlot_2;
                    latDNext     = pending - 8'd1;
                    stateNext    = S_ROLLBACK;
                end else begin
                    if (fetchAcc) begin
                        ghrNext = ghrFetch;
                    end
                    pendingNext = pending - {7'd0, correct}
                                + {5'd0, (fetchAcc ? passB : 3'd0)};
                end
            end
            S_ROLLBACK: begin
                ghrNext     = {ghrRb[179:1], latTaken};
                pendingNext = 8'd0;
                idxNext     = 4'd0;
                stateNext   = S_TRAIN;
            end
            S_TRAIN: begin
                weightsNext[wBase +: 8] = newW;
                if (idx == 4'd8) begin
                    stateNext     = S_DONE;
                    trainDoneNext = 1'b1;
                end else begin
                    idxNext = idx + 4'd1;
                end
            end
            S_DONE: begin
                stateNext = S_IDLE;
            end
            default: begin
                stateNext = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears any partial training.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= S_IDLE;
            ghr       <= '0;
            pending   <= '0;
            weights   <= '0;
            idx       <= '0;
            latTaken  <= 1'b0;
            latSlot   <= '0;
            latD      <= '0;
            trainDone <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state     <= stateNext;
            ghr       <= ghrNext;
            pending   <= pendingNext;
            weights   <= weightsNext;
            idx       <= idxNext;
            latTaken  <= latTakenNext;
            latSlot   <= latSlotNext;
            latD      <= latDNext;
            trainDone <= trainDoneNext;
            underflow <= underflowNext;
        end
    end

    assign bus.o_fetchReady  = fetchReady;
    assign bus.o_ghr_180     = ghr;
    assign bus.o_pendingB_8  = pending;
    assign bus.o_weights_288 = weights;
    assign bus.o_busy        = (state != S_IDLE);
    assign bus.o_trainDone   = trainDone;
    assign bus.o_underflow   = underflow;
    assign bus.o_dbgState    = state;
endmodule

// File: tb/tb_bpred_history_ctrl.sv
// Bench for bpred_history_ctrl: directed scenarios plus random traffic,
// all checked every cycle against an array-based reference model.
module tb_bpred_history_ctrl;
    logic i_clk;
    logic i_rst;
    bpred_history_ctrl_if bus();

    bpred_history_ctrl dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    // Clock and reset.
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int nChecks = 0;
    int errCount = 0;

    // Reference model: history as an array of entries, weights as ints.
    int mg[20];
    int mpend;
    int mw[4][9];
    int mphase;      // 0 idle, 1 rollback, 2..10 training, 11 done
    int mTaken, mSlot, mD;
    bit expDone, expUnder;

    task automatic check(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        nChecks++;
        if (obs !== exp) begin
            errCount++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 20; k++) mg[k] = 0;
        for (int s = 0; s < 4; s++)
            for (int j = 0; j < 9; j++) mw[s][j] = 0;
        mpend = 0; mphase = 0; mTaken = 0; mSlot = 0; mD = 0;
        expDone = 0; expUnder = 0;
    endtask

    task automatic modelStep();
        int p, idx;
        bit rOk, misp, fOk, up;
        logic [35:0] ent;
        expDone = 0;
        expUnder = 0;
        if (mphase == 0) begin
            p = (bus.i_passBNum_3 > 3'd4) ? 4 : int'(bus.i_passBNum_3);
            rOk = bus.i_resolveValid;
            if (rOk && mpend == 0) expUnder = 1;
            misp = rOk && mpend > 0 && (bus.i_resolveTaken != bus.i_resolvePredTaken);
            fOk = bus.i_fetchValid && mpend <= 16 && !bus.i_fetchErr && !misp;
            if (misp) begin
                mTaken = int'(bus.i_resolveTaken);
                mSlot  = int'(bus.i_resolveSlot_2);
                mD     = mpend - 1;
                mphase = 1;
            end else begin
                if (rOk && mpend > 0) mpend--;
                if (fOk) begin
                    ent = bus.i_newGHREntry_36;
                    for (int k = 19; k >= 0; k--) begin
                        if (k >= p) mg[k] = mg[k-p];
                        else mg[k] = int'((ent >> (9*k)) & 36'h1FF);
                    end
                    mpend += p;
                end
            end
        end else if (mphase == 1) begin
            for (int k = 0; k < 20; k++) mg[k] = (k + mD < 20) ? mg[k+mD] : 0;
            mg[0] = (mg[0] & 'h1FE) | mTaken;
            mpend = 0;
            mphase = 2;
        end else if (mphase <= 10) begin
            idx = mphase - 2;
            up = (idx < 8) ? ((mg[idx+1] & 1) == mTaken) : (mTaken == 1);
            if (up) mw[mSlot][idx] = (mw[mSlot][idx] >= 127) ? 127 : mw[mSlot][idx] + 1;
            else    mw[mSlot][idx] = (mw[mSlot][idx] <= -128) ? -128 : mw[mSlot][idx] - 1;
            if (mphase == 10) expDone = 1;
            mphase++;
        end else begin
            mphase = 0;
        end
    endtask

    function automatic logic [179:0] packGhr();
        logic [179:0] r;
        r = '0;
        for (int k = 0; k < 20; k++) r[k*9 +: 9] = 9'(mg[k]);
        return r;
    endfunction

    function automatic logic [287:0] packW();
        logic [287:0] r;
        r = '0;
        for (int s = 0; s < 4; s++)
            for (int j = 0; j < 9; j++) r[s*72 + j*8 +: 8] = 8'(mw[s][j]);
        return r;
    endfunction

    task automatic checkAll();
        check("ghr",       288'(bus.o_ghr_180),     288'(packGhr()));
        check("pending",   288'(bus.o_pendingB_8),  288'(mpend));
        check("weights",   bus.o_weights_288,       packW());
        check("ready",     288'(bus.o_fetchReady),  288'(mphase == 0 && mpend <= 16));
        check("busy",      288'(bus.o_busy),        288'(mphase != 0));
        check("trainDone", 288'(bus.o_trainDone),   288'(expDone));
        check("underflow", 288'(bus.o_underflow),   288'(expUnder));
    endtask

    // Driver tasks.
    task automatic drive(input bit fv, input bit err, input int p, input logic [35:0] ent,
                         input bit rv, input bit rt, input bit rp, input int slot);
        bus.i_fetchValid       = fv;
        bus.i_fetchErr         = err;
        bus.i_passBNum_3       = 3'(p);
        bus.i_newGHREntry_36   = ent;
        bus.i_resolveValid     = rv;
        bus.i_resolveTaken     = rt;
        bus.i_resolvePredTaken = rp;
        bus.i_resolveSlot_2    = 2'(slot);
    endtask

    task automatic idleIn();
        drive(0, 0, 0, 36'd0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge i_clk);
        if (!i_rst) modelStep();
        #1;
        checkAll();
    endtask

    task automatic doReset();
        i_rst = 1'b1;
        idleIn();
        repeat (2) @(posedge i_clk);
        modelReset();
        #1;
        checkAll();
        i_rst = 1'b0;
    endtask

    int busyCycles, doneAt;
    logic [35:0] ent;
    bit fv, rv, rt, rp;

    initial begin
        i_rst = 1'b1;
        idleIn();
        modelReset();

        // Reset values.
        doReset();
        check("rst_ghr",   288'(bus.o_ghr_180), 288'd0);
        check("rst_pend",  288'(bus.o_pendingB_8), 288'd0);
        check("rst_w",     bus.o_weights_288, 288'd0);
        check("rst_ready", 288'(bus.o_fetchReady), 288'd1);
        check("rst_busy",  288'(bus.o_busy), 288'd0);
        check("rst_state", 288'(bus.o_dbgState), 288'd0);

        // Fetch P=3 then P=1.
        drive(1, 0, 3, {9'h000, 9'h101, 9'h002, 9'h1FF}, 0, 0, 0, 0); tick();
        drive(1, 0, 1, {27'd0, 9'h003}, 0, 0, 0, 0); tick();
        check("f_e0", 288'(bus.o_ghr_180[8:0]),   288'h003);
        check("f_e1", 288'(bus.o_ghr_180[17:9]),  288'h1FF);
        check("f_e2", 288'(bus.o_ghr_180[26:18]), 288'h002);
        check("f_e3", 288'(bus.o_ghr_180[35:27]), 288'h101);
        check("f_pend", 288'(bus.o_pendingB_8), 288'd4);

        // pending=5, then a correct resolve together with a P=2 fetch.
        drive(1, 0, 1, {27'd0, 9'h055}, 0, 0, 0, 0); tick();
        drive(1, 0, 2, {18'd0, 9'h0AA, 9'h0F0}, 1, 1, 1, 0); tick();
        idleIn();
        check("fr_pend", 288'(bus.o_pendingB_8), 288'd6);
        check("fr_e0", 288'(bus.o_ghr_180[8:0]),   288'h0F0);
        check("fr_e1", 288'(bus.o_ghr_180[17:9]),  288'h0AA);
        check("fr_e2", 288'(bus.o_ghr_180[26:18]), 288'h055);
        check("fr_e3", 288'(bus.o_ghr_180[35:27]), 288'h003);

        // Mispredict with pending=4 and a known taken-bit pattern.
        doReset();
        drive(1, 0, 4, {9'h0D6, 9'h0C5, 9'h0B4, 9'h0A3}, 0, 0, 0, 0); tick();
        drive(1, 0, 4, {9'h0D6, 9'h0C5, 9'h0B4, 9'h0A3}, 0, 0, 0, 0); tick();
        drive(1, 0, 4, {9'h1E2, 9'h111, 9'h022, 9'h033}, 0, 0, 0, 0); tick();
        repeat (8) begin
            drive(0, 0, 0, 36'd0, 1, 0, 0, 0); tick();
        end
        check("m_pend4", 288'(bus.o_pendingB_8), 288'd4);
        drive(1, 0, 4, 36'hFFFFFFFFF, 1, 1, 0, 2); tick();
        busyCycles = int'(bus.o_busy);
        doneAt = -1;
        for (int c = 1; c <= 12; c++) begin
            idleIn();
            tick();
            if (c == 1) begin
                check("m_e0", 288'(bus.o_ghr_180[8:0]), 288'h1E3);
                check("m_pend0", 288'(bus.o_pendingB_8), 288'd0);
            end
            busyCycles += int'(bus.o_busy);
            if (bus.o_trainDone) doneAt = c + 1;
        end
        check("m_busy11", 288'(busyCycles), 288'd11);
        check("m_doneAt", 288'(doneAt), 288'd11);
        check("m_w2", 288'(bus.o_weights_288[2*72 +: 72]), 288'h01FF01FF01FF01FF01);
        check("m_w0", 288'(bus.o_weights_288[71:0]), 288'd0);

        // Bias saturation on slot 0 with fetches attempted while busy.
        doReset();
        repeat (130) begin
            drive(1, 0, 1, {27'd0, 9'($urandom)}, 0, 0, 0, 0); tick();
            drive(0, 0, 0, 36'd0, 1, 1, 0, 0); tick();
            repeat (11) begin
                drive(1, 0, 4, {4'($urandom_range(0, 15)), 32'($urandom)}, 0, 0, 0, 0);
                tick();
            end
            idleIn();
        end
        check("sat_bias", 288'(bus.o_weights_288[8*8 +: 8]), 288'h7F);
        check("sat_pend", 288'(bus.o_pendingB_8), 288'd0);

        // pending 17 blocks fetch.
        doReset();
        repeat (4) begin
            drive(1, 0, 4, {4'($urandom_range(0, 15)), 32'($urandom)}, 0, 0, 0, 0); tick();
        end
        check("p16_ready", 288'(bus.o_fetchReady), 288'd1);
        drive(1, 0, 1, 36'h1AB, 0, 0, 0, 0); tick();
        check("p17_ready", 288'(bus.o_fetchReady), 288'd0);
        drive(1, 0, 4, 36'h123456789, 0, 0, 0, 0); tick();
        check("p17_pend", 288'(bus.o_pendingB_8), 288'd17);

        // Underflow at pending 0.
        doReset();
        drive(0, 0, 0, 36'd0, 1, 1, 0, 1); tick();
        check("uf_pulse", 288'(bus.o_underflow), 288'd1);
        check("uf_busy", 288'(bus.o_busy), 288'd0);
        idleIn(); tick();
        check("uf_clear", 288'(bus.o_underflow), 288'd0);
        check("uf_pend", 288'(bus.o_pendingB_8), 288'd0);

        // Reset asserted during training.
        doReset();
        drive(1, 0, 2, {18'd0, 9'h001, 9'h001}, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 36'd0, 1, 1, 0, 3); tick();
        idleIn();
        repeat (5) tick();
        check("rt_busy_pre", 288'(bus.o_busy), 288'd1);
        #2;
        i_rst = 1'b1;
        #1;
        modelReset();
        check("rt_ghr",   288'(bus.o_ghr_180), 288'd0);
        check("rt_pend",  288'(bus.o_pendingB_8), 288'd0);
        check("rt_w",     bus.o_weights_288, 288'd0);
        check("rt_ready", 288'(bus.o_fetchReady), 288'd1);
        check("rt_busy",  288'(bus.o_busy), 288'd0);
        check("rt_done",  288'(bus.o_trainDone), 288'd0);

        // Random traffic against the model.
        doReset();
        for (int n = 0; n < 800; n++) begin
            fv  = ($urandom_range(0, 1) == 1);
            ent = {4'($urandom_range(0, 15)), 32'($urandom)};
            rv  = ($urandom_range(0, 3) == 0) && (mphase == 0);
            rt  = ($urandom_range(0, 1) == 1);
            rp  = ($urandom_range(0, 3) == 0) ? !rt : rt;
            if (rv && mpend == 0) fv = 0;
            drive(fv, ($urandom_range(0, 7) == 0), int'($urandom_range(0, 7)), ent,
                  rv, rt, rp, int'($urandom_range(0, 3)));
            tick();
        end
        idleIn();

        $display("Simulation finished: %0d checks, %0d errors", nChecks, errCount);
        $finish;
    end
endmodule

// File: doc/bpred_history_ctrl.md
# bpred_history_ctrl

Stateful controller for the branch predict-and-learning datapath. It owns the global history register (GHR), the pending-branch count and the perceptron weight set, and feeds them to the predictor every cycle. It commits the predictor's per-fetch history update, retires resolved conditional branches from execute, and on a mispredict rolls the GHR back and trains the weights through a multi-cycle state machine.

## Interface
- No parameters. GHR depth is 20 entries × 9 bits, with 4 weight slots × 9 weights × 8 bits.
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous reset, active-high.
- i_fetchValid  in  1  the predictor result for the current fetch group is valid.
- i_fetchErr  in  1  predictor `gotErr`. When high, the fetch update is ignored.
- i_passBNum_3  in  3  number of B entries to commit, 0..4. Values above 4 are treated as 4.
- i_newGHREntry_36  in  36  new entries. Entry k is at [k*9+:9]; entry 0 is youngest. Bit 0 is the taken flag and bits 8:1 are the PC tag.
- o_fetchReady  out  1  a fetch update can be accepted.
- i_resolveValid  in  1  the oldest pending B resolved this cycle.
- i_resolveTaken  in  1  actual outcome.
- i_resolvePredTaken  in  1  predicted outcome.
- i_resolveSlot_2  in  2  weight slot used for the prediction.
- o_ghr_180  out  180  GHR. Entry n is at [n*9+:9]; entry 0 is youngest.
- o_pendingB_8  out  8  count of unresolved predicted B, 0..20.
- o_weights_288  out  288  weight w[s][j] is at [s*72+j*8+:8]; j=8 is the bias. Signed two's complement.
- o_busy  out  1  rollback or training is in progress.
- o_trainDone  out  1  one-cycle pulse when training completes.
- o_underflow  out  1  one-cycle pulse when a resolve arrives while pending is 0.

## Operation
- Reset values: GHR 0, pending 0, all weights 0, state IDLE, o_busy 0, pulse outputs 0, o_fetchReady 1.
- o_fetchReady = (state==IDLE) && (pending ≤ 16). It is a function of registered state only.
- Fetch accepted = i_fetchValid && o_fetchReady && !i_fetchErr && !mispredict, where P = min(i_passBNum_3, 4).
  - GHR_next = ((GHR << 9P) | (i_newGHREntry_36 masked to the low 9P bits)), truncated to 180 bits. Entries shifted past index 19 are lost.
  - pending += P.
- Resolve is valid only in IDLE. It is ignored in other states, and execute must not resolve while o_busy is high.
  - If pending == 0: pulse o_underflow and change no state.
  - mispredict = i_resolveValid && pending>0 && (i_resolveTaken != i_resolvePredTaken).
  - Correct resolve: pending −= 1. The GHR is unchanged.
  - Simultaneous accepted fetch and correct resolve: pending = pending + P − 1, and the GHR takes the fetch update.
  - Mispredict: the fetch in the same cycle is dropped. Latch taken, slot and D = pending − 1, then enter ROLLBACK.
- States:
  - IDLE.
  - ROLLBACK, 1 cycle:
    - GHR >>= 9D, zero-filling the old end, so the resolved branch becomes entry 0.
    - Set entry 0 bit 0 to the latched taken value.
    - pending = 0.
    - Go to TRAIN with idx = 0.
  - TRAIN, 9 cycles, idx 0..8, one weight per cycle:
    - For idx < 8: w[slot][idx] += (GHR entry idx+1 bit 0 == taken) ? +1 : −1.
    - For idx = 8: bias += taken ? +1 : −1.
    - Saturate at +127 / −128.
    - After idx 8, go to DONE.
  - DONE, 1 cycle: pulse o_trainDone, then go to IDLE.
- o_busy = (state != IDLE).
- Reset asserted mid-training returns to reset values immediately. Partially trained weights are discarded because weights reset to 0.

## Timing
- All outputs are registered. A fetch or resolve at edge t is visible at t+1.
- Mispredict sampled at edge t: ROLLBACK at t+1, TRAIN from t+2 to t+10, DONE at t+11 with o_trainDone high during that cycle, IDLE at t+12.
- o_busy is high from t+1 through t+11.
- o_fetchReady is low from t+1 until IDLE.
- o_fetchReady is also low while pending > 16, because one group can add 4 entries and the count must not exceed 20.

## Test plan
- Reset, then check outputs: o_ghr_180=0, o_pendingB_8=0, o_weights_288=0, o_fetchReady=1, o_busy=0.
- Fetch with P=3 and entries {0x1FF, 0x002, 0x101}, then P=1 with entry 0x003:
  - Required: GHR entry0=0x003, entry1=0x1FF, entry2=0x002, entry3=0x101, pending=4.
- pending=5 with a correct resolve in the same cycle as a fetch with P=2:
  - Required: pending=6 and the GHR shifted by 2 entries.
- pending=4 and mispredict (taken=1, pred=0, slot=2) with entry3 bit0=0 and entries 4..11 bit0 = 1,0,1,0,1,0,1,0:
  - Required: entry0 bit0=1 and pending=0.
  - Required: w[2][0..7] = +1,−1,+1,−1,+1,−1,+1,−1 and bias=+1.
  - Required: o_trainDone pulses at t+11, and o_busy is high for 11 cycles.
- Preload w[0][8]=+127 via repeated taken mispredicts on slot 0:
  - Required: the bias stays +127 and does not wrap.
  - Required: a concurrent fetch during o_busy is not accepted.
- Drive pending to 17: o_fetchReady=0. A resolve at pending 0 produces an o_underflow pulse and leaves the state unchanged. Asserting i_rst in TRAIN returns all outputs to reset values immediately.
